// File: rtl/ldpc_enc_sched.sv
// Block-serial QC-LDPC parity scheduler: buffers the info circulants, walks the
// prototype shift table one entry per cycle, and XOR-accumulates rotated blocks.
module ldpc_enc_sched #(
    parameter int Z               = 54,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int SHIFT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Z-1:0]          in_blk,
    output logic                  mem_rd_en,
    output logic [((NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1)-1:0] mem_row,
    output logic [((NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1)-1:0]     mem_col,
    input  logic [SHIFT_W-1:0]    mem_shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Z-1:0]          out_blk,
    output logic                  out_last,
    output logic                  cfg_err
);

    localparam int unsigned RW = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1;
    localparam int unsigned CW = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
    localparam logic [CW-1:0]      LAST_COL = CW'(NUM_INFO_BLKS - 1);
    localparam logic [RW-1:0]      LAST_ROW = RW'(NUM_PARITY_BLKS - 1);
    localparam logic [SHIFT_W:0]   ZLIM     = (SHIFT_W + 1)'(Z);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [Z-1:0]    blk_buf [NUM_INFO_BLKS];
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_d;
    logic [RW-1:0]   row;
    logic            rd_d;
    logic [Z-1:0]    acc;
    logic [2*Z-1:0]  rot_dbl;
    logic [Z-1:0]    rot;
    logic            shift_legal;
    logic            shift_skip;
    logic            in_fire;
    logic            out_fire;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_rd_en = 1'b0;
        mem_row   = '0;
        mem_col   = '0;
        out_valid = 1'b0;
        out_blk   = '0;
        out_last  = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LAST_COL))
                    state_nxt = COMPUTE;
            end
            COMPUTE: begin
                mem_rd_en = 1'b1;
                mem_row   = row;
                mem_col   = col;
                if (col == LAST_COL)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                out_blk   = acc;
                out_last  = (row == LAST_ROW);
                if (out_ready)
                    state_nxt = (row == LAST_ROW) ? LOAD : COMPUTE;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Rotate-left by s: upper half of the doubled vector shifted left by s.
    always_comb begin
        rot_dbl = {blk_buf[col_d], blk_buf[col_d]} << mem_shift;
        rot     = rot_dbl[2*Z-1:Z];
    end

    assign shift_skip  = &mem_shift;
    assign shift_legal = !mem_shift[SHIFT_W-1] && ({1'b0, mem_shift} < ZLIM);

    always_ff @(posedge clk) begin
        if (in_fire)
            blk_buf[cnt] <= in_blk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            cnt     <= '0;
            col     <= '0;
            col_d   <= '0;
            row     <= '0;
            rd_d    <= 1'b0;
            acc     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_d  <= mem_rd_en;
            col_d <= col;

            // Shift data returns one cycle after the read; DRAIN covers the last entry.
            if (rd_d) begin
                if (shift_legal)
                    acc <= acc ^ rot;
                else if (!shift_skip)
                    cfg_err <= 1'b1;
            end

            if (in_fire) begin
                if (cnt == LAST_COL) begin
                    cnt <= '0;
                    row <= '0;
                    col <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (mem_rd_en)
                col <= (col == LAST_COL) ? '0 : col + 1'b1;

            if (out_fire) begin
                acc <= '0;
                col <= '0;
                if (row == LAST_ROW) begin
                    row <= '0;
                    cnt <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_enc_sched.sv
// Directed bench for ldpc_enc_sched: shift-table model plus hand-computed parity blocks.
module tb_ldpc_enc_sched;

    localparam int Z  = 54;
    localparam int NI = 20;
    localparam int NP = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [Z-1:0]  in_blk;
    logic          mem_rd_en;
    logic [1:0]    mem_row;
    logic [4:0]    mem_col;
    logic [SW-1:0] mem_shift;
    logic          out_valid;
    logic          out_ready;
    logic [Z-1:0]  out_blk;
    logic          out_last;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int scen   = 0;
    int ref_c;
    int hs_c;
    logic [Z-1:0] exp_blk [NP];

    ldpc_enc_sched #(
        .Z(Z),
        .NUM_INFO_BLKS(NI),
        .NUM_PARITY_BLKS(NP),
        .SHIFT_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_blk(in_blk),
        .mem_rd_en(mem_rd_en),
        .mem_row(mem_row),
        .mem_col(mem_col),
        .mem_shift(mem_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_blk(out_blk),
        .out_last(out_last),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: all zero, 1: only (0,0)=53 rest -1, 2: (2,5)=60 rest zero
    function automatic logic [SW-1:0] tbl(input int r, input int c);
        case (scen)
            1:       return (r == 0 && c == 0) ? 8'd53 : 8'hFF;
            2:       return (r == 2 && c == 5) ? 8'd60 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk)
        if (mem_rd_en) mem_shift <= tbl(int'(mem_row), int'(mem_col));

    function automatic logic [Z-1:0] info(input int mode, input int k);
        if (mode == 0) return Z'(k + 1);
        return (k == 0) ? Z'(1) : '0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cw(input int mode, output int last_c);
        last_c = cyc;
        for (int k = 0; k < NI; k++) begin
            int n = 0;
            in_valid = 1'b1;
            in_blk   = info(mode, k);
            while (in_ready !== 1'b1 && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            last_c = cyc;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input logic [Z-1:0] e, input logic el, input int refc,
                        input int bp, output int hs);
        int n = 0;
        hs = cyc;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            return;
        end
        chk("latency", 64'(cyc - refc), 64'd22);
        chk("out_blk", 64'(out_blk), 64'(e));
        chk("out_last", 64'(out_last), 64'(el));
        for (int b = 0; b < bp; b++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_blk", 64'(out_blk), 64'(e));
            chk("bp_rd_en", 64'(mem_rd_en), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        hs = cyc;
        step();
        out_ready = 1'b0;
    endtask

    task automatic recv_cw(input int refc, input int bp_row);
        int r = refc;
        for (int p = 0; p < NP; p++) begin
            recv(exp_blk[p], (p == NP - 1), r, (p == bp_row) ? 10 : 0, r);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_blk    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset from an arbitrary state (mid COMPUTE)
        send_cw(0, ref_c);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_row", 64'(mem_row), 64'd0);
        chk("rst_col", 64'(mem_col), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_blk", 64'(out_blk), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // all-zero shifts: XOR of 1..20 is 20
        scen = 0;
        for (int p = 0; p < NP; p++) exp_blk[p] = Z'(20);
        send_cw(0, ref_c);
        recv_cw(ref_c, -1);
        chk("zero_cfg_err", 64'(cfg_err), 64'd0);

        // wrap rotation: rotl(1,53) = bit 53
        scen = 1;
        exp_blk[0] = 54'h20_0000_0000_0000;
        for (int p = 1; p < NP; p++) exp_blk[p] = '0;
        send_cw(1, ref_c);
        recv_cw(ref_c, -1);
        chk("wrap_cfg_err", 64'(cfg_err), 64'd0);

        // backpressure on row 1
        scen = 0;
        for (int p = 0; p < NP; p++) exp_blk[p] = Z'(20);
        send_cw(0, ref_c);
        recv_cw(ref_c, 1);

        // illegal shift at (2,5): row 2 drops block 6 -> 20^6 = 18
        scen = 2;
        exp_blk[2] = Z'(18);
        send_cw(0, ref_c);
        recv_cw(ref_c, -1);
        chk("illegal_cfg_err", 64'(cfg_err), 64'd1);
        scen = 0;
        exp_blk[2] = Z'(20);
        send_cw(0, ref_c);
        chk("sticky_cfg_err_mid", 64'(cfg_err), 64'd1);
        recv_cw(ref_c, -1);
        chk("sticky_cfg_err_end", 64'(cfg_err), 64'd1);

        // reset during COMPUTE of row 1, then a clean codeword
        send_cw(0, ref_c);
        recv(Z'(20), 1'b0, ref_c, 0, hs_c);
        step();
        step();
        step();
        chk("mid_rd_en", 64'(mem_rd_en), 64'd1);
        chk("mid_row", 64'(mem_row), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        send_cw(0, ref_c);
        recv_cw(ref_c, -1);
        chk("final_cfg_err", 64'(cfg_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
